alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Multi-cycle fetch/decode/sequencer that drives the 16-bit ALU's OP and operand selects.
- Consumes the ALU's ZERO/EQUAL/BRANCH/OUT results to advance the program counter.
- Sits between instruction memory, the register file and the ALU; it is the issuing end of the ALU opcode interface.

Parameters:
- PC_W, 8, program counter and IMEM address width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on RESET.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  leaves IDLE, begins fetching at current PC.
- IMEM_ADDR  out  PC_W  fetch address (= PC).
- IMEM_RD  out  1  fetch request; held until IMEM_VALID.
- IMEM_DATA  in  16  instruction word; valid when IMEM_VALID.
- IMEM_VALID  in  1  fetch response strobe.
- OP  out  4  ALU opcode = IR[15:12]; 0 outside DECODE/EXECUTE/WRITEBACK.
- RD_ADDR  out  4  IR[11:8]; destination register, or first source for branches.
- RA_ADDR  out  4  IR[7:4].
- RB_ADDR  out  4  IR[3:0].
- RF_WE  out  1  register write strobe, one cycle.
- MEM_WE  out  1  data memory write strobe, one cycle.
- ZERO, EQUAL  in  1 each  ALU flags.
- BRANCH  in  2  ALU branch decision.
- ALU_OUT  in  16  ALU result; low PC_W bits used as absolute target.
- PC  out  PC_W  current PC.
- BUSY  out  1  high in any state except IDLE and HALTED.
- HALTED  out  1  high in HALTED.
- ILLEGAL  out  1  sticky; set when a reserved opcode is decoded.
- INSTR_CNT  out  CNT_W  retired instructions; wraps to 0.

Behaviour:
- Reset values: state IDLE, PC=RESET_PC, IR=0, INSTR_CNT=0. All outputs 0 except IMEM_ADDR=RESET_PC.
- RESET overrides everything in any state, including a pending fetch; an IMEM_VALID arriving after reset is ignored.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- IDLE -> FETCH when START=1. START is ignored in every other state.
- FETCH:
  - IMEM_RD=1, IMEM_ADDR=PC.
  - On IMEM_VALID: IR<=IMEM_DATA, go to DECODE. Same-cycle VALID gives zero wait; otherwise wait indefinitely.
- DECODE: OP and address outputs driven from IR. One cycle, so register-file reads settle.
- EXECUTE: ALU is combinational; FSM samples BRANCH and ALU_OUT at end of cycle. -> WRITEBACK.
- WRITEBACK, by opcode:
  - 0 nop: no strobe.
  - 1 halt: -> HALTED next cycle. PC not advanced; INSTR_CNT incremented.
  - 2 sub, 3 wr, 4 search, 7 smr, 8 rxor, 9 srl: RF_WE=1.
  - 6 wm: MEM_WE=1.
  - 5 beq, 10 bsq: no strobe; PC from BRANCH.
  - 11-15: treated as nop, ILLEGAL<=1.
- PC update in WRITEBACK (non-halt):
  - BRANCH=00 or 11: PC+1.
  - BRANCH=01: PC+1+sext(IR[3:0]), modulo 2^PC_W.
  - BRANCH=10: ALU_OUT[PC_W-1:0].
  - BRANCH is honoured only for opcodes 5 and 10; all other opcodes use PC+1.
- Leaving WRITEBACK (non-halt): INSTR_CNT+1, go to FETCH. Minimum 4 cycles per instruction.
- HALTED is terminal until RESET. OP=0, no strobes, PC frozen.
- Boundaries:
  - PC=2^PC_W-1 with fall-through wraps to 0.
  - Branch offset -8 from PC 0 wraps.
  - INSTR_CNT all-ones wraps to 0.
  - RF_WE and MEM_WE are never high together.

Decomposition:
- Shared package alu_isa_pkg holds:
  - opcode constants OP_NOP..OP_BSQ (0-10);
  - branch encodings BR_NONE=00, BR_REL=01, BR_ABS=10;
  - state enum;
  - IR field slice constants.
- The ALU reuses the same opcode constants.
- One natural sub-module: alu_ctrl_pc (PC register plus next-PC mux and wrap arithmetic).

Test Plan:
- Reset then START, IMEM returns 16'h2123 at PC 0 after 2-cycle wait -> OP=2, RD=1, RA=2, RB=3, RF_WE pulse once, PC=1, INSTR_CNT=1.
- beq 16'h512E at PC 5 with BRANCH=01 -> PC=5+1-2=4; with BRANCH=00 -> PC=6. No RF_WE or MEM_WE.
- bsq with BRANCH=10, ALU_OUT=16'h00A7 -> PC=8'hA7. A nop (opcode 0) with BRANCH=10 forced -> PC+1.
- Program wm (16'h6000) then halt (16'h1000) -> one MEM_WE pulse, then HALTED=1, BUSY=0, PC frozen. Further START and IMEM_VALID are ignored.
- Opcode 16'hC000 -> no strobes, ILLEGAL=1 and stays set; next instruction fetches normally. Fetch at PC=8'hFF with fall-through -> PC=0.
- RESET asserted while in FETCH with IMEM_RD high -> next cycle IDLE, PC=0, IMEM_RD=0. A late IMEM_VALID causes no IR change.

Source files
------------

// File: rtl/alu_isa_pkg.sv
// Shared ISA definitions for the ALU and its control sequencer: opcodes,
// branch encodings, IR field positions and the sequencer state enum.
package alu_isa_pkg;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_HALT   = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_WR     = 4'd3;
    localparam logic [3:0] OP_SEARCH = 4'd4;
    localparam logic [3:0] OP_BEQ    = 4'd5;
    localparam logic [3:0] OP_WM     = 4'd6;
    localparam logic [3:0] OP_SMR    = 4'd7;
    localparam logic [3:0] OP_RXOR   = 4'd8;
    localparam logic [3:0] OP_SRL    = 4'd9;
    localparam logic [3:0] OP_BSQ    = 4'd10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_REL  = 2'b01;
    localparam logic [1:0] BR_ABS  = 2'b10;

    localparam int IR_OP_MSB = 15;
    localparam int IR_OP_LSB = 12;
    localparam int IR_RD_MSB = 11;
    localparam int IR_RD_LSB = 8;
    localparam int IR_RA_MSB = 7;
    localparam int IR_RA_LSB = 4;
    localparam int IR_RB_MSB = 3;
    localparam int IR_RB_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5
    } state_t;

    // Opcodes above OP_BSQ are reserved and execute as a nop.
    function automatic logic is_reserved(input logic [3:0] op);
        return op > OP_BSQ;
    endfunction

endpackage

// File: rtl/alu_ctrl_pc.sv
// Program counter with next-PC selection: fall-through, PC-relative
// (sign-extended 4-bit offset) or absolute target; all arithmetic wraps.
module alu_ctrl_pc import alu_isa_pkg::*; #(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic [1:0]      br_sel_i,
    input  logic [3:0]      offset_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] offset_sext;

    assign pc_inc      = pc_q + PC_W'(1);
    assign offset_sext = {{(PC_W-4){offset_i[3]}}, offset_i};

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            case (br_sel_i)
                BR_REL:  pc_d = pc_inc + offset_sext;
                BR_ABS:  pc_d = target_i;
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= PC_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle fetch/decode/execute/writeback sequencer issuing opcodes and
// register selects to the 16-bit ALU and advancing the PC from its results.
module alu_ctrl_seq import alu_isa_pkg::*; #(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    output logic [PC_W-1:0]  imem_addr_o,
    output logic             imem_rd_o,
    input  logic [15:0]      imem_data_i,
    input  logic             imem_valid_i,
    output logic [3:0]       op_o,
    output logic [3:0]       rd_addr_o,
    output logic [3:0]       ra_addr_o,
    output logic [3:0]       rb_addr_o,
    output logic             rf_we_o,
    output logic             mem_we_o,
    input  logic             zero_i,
    input  logic             equal_i,
    input  logic [1:0]       branch_i,
    input  logic [15:0]      alu_out_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output state_t           state_o
);

    state_t           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic [1:0]       br_q, br_d;
    logic [PC_W-1:0]  tgt_q, tgt_d;
    logic             pc_load;
    logic [1:0]       br_eff;
    logic [3:0]       ir_op;
    logic [PC_W-1:0]  pc;
    logic             unused_inputs;

    assign ir_op  = ir_q[IR_OP_MSB:IR_OP_LSB];
    // Only the two branch opcodes may redirect the PC; everything else falls through.
    assign br_eff = (ir_op == OP_BEQ || ir_op == OP_BSQ) ? br_q : BR_NONE;

    // IMEM handshake: imem_rd_o rises on entry to FETCH and stays high until the
    // cycle imem_valid_i is sampled high; a response outside FETCH is dropped.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        br_d      = br_q;
        tgt_d     = tgt_q;
        pc_load   = 1'b0;
        imem_rd_o = 1'b0;
        rf_we_o   = 1'b0;
        mem_we_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_rd_o = 1'b1;
                if (imem_valid_i) begin
                    ir_d    = imem_data_i;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_reserved(ir_op)) illegal_d = 1'b1;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                br_d    = branch_i;
                tgt_d   = alu_out_i[PC_W-1:0];
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                case (ir_op)
                    OP_SUB, OP_WR, OP_SEARCH, OP_SMR, OP_RXOR, OP_SRL: rf_we_o = 1'b1;
                    OP_WM:   mem_we_o = 1'b1;
                    default: ;
                endcase
                if (ir_op == OP_HALT) begin
                    state_d = ST_HALTED;
                end else begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            br_q      <= BR_NONE;
            tgt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            br_q      <= br_d;
            tgt_q     <= tgt_d;
        end
    end

    alu_ctrl_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (pc_load),
        .br_sel_i (br_eff),
        .offset_i (ir_q[IR_RB_MSB:IR_RB_LSB]),
        .target_i (tgt_q),
        .pc_o     (pc)
    );

    assign op_o = (state_q == ST_DECODE || state_q == ST_EXECUTE ||
                   state_q == ST_WRITEBACK) ? ir_op : 4'd0;
    assign rd_addr_o   = ir_q[IR_RD_MSB:IR_RD_LSB];
    assign ra_addr_o   = ir_q[IR_RA_MSB:IR_RA_LSB];
    assign rb_addr_o   = ir_q[IR_RB_MSB:IR_RB_LSB];
    assign imem_addr_o = pc;
    assign pc_o        = pc;
    assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign halted_o    = (state_q == ST_HALTED);
    assign illegal_o   = illegal_q;
    assign instr_cnt_o = cnt_q;
    assign state_o     = state_q;

    // Flags are consumed by the ALU's own branch decision, not here.
    assign unused_inputs = ^{zero_i, equal_i, alu_out_i[15:PC_W]};

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed program table, halt/reset corner cases and
// a randomized instruction stream checked against a behavioural model.
module tb_alu_ctrl_seq;
    import alu_isa_pkg::*;

    localparam int PC_W  = 8;
    localparam int CNT_W = 4;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset, start, imem_valid, zero, equal;
    logic [15:0]      imem_data, alu_out;
    logic [1:0]       branch;
    logic [PC_W-1:0]  imem_addr, pc;
    logic             imem_rd, rf_we, mem_we, busy, halted, illegal;
    logic [3:0]       op, rd_addr, ra_addr, rb_addr;
    logic [CNT_W-1:0] instr_cnt;
    state_t           state;

    int total = 0;
    int bad   = 0;

    alu_ctrl_seq #(.PC_W(PC_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .imem_addr_o(imem_addr), .imem_rd_o(imem_rd),
        .imem_data_i(imem_data), .imem_valid_i(imem_valid),
        .op_o(op), .rd_addr_o(rd_addr), .ra_addr_o(ra_addr), .rb_addr_o(rb_addr),
        .rf_we_o(rf_we), .mem_we_o(mem_we),
        .zero_i(zero), .equal_i(equal), .branch_i(branch), .alu_out_i(alu_out),
        .pc_o(pc), .busy_o(busy), .halted_o(halted), .illegal_o(illegal),
        .instr_cnt_o(instr_cnt), .state_o(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        int          wt;
        logic [1:0]  br;
        logic [15:0] alu;
        int          e_op, e_rf, e_mem, e_pc, e_ill, e_halt;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Acts as IMEM and ALU for one instruction; returns at the first negedge after WRITEBACK.
    task automatic run_instr(input logic [15:0] instr, input int wt, input logic [1:0] br,
                             input logic [15:0] alu, output int f_addr, output int op_seen,
                             output int regs_seen, output int rf_n, output int mem_n,
                             output int both, output int rd_hold, output int op_after);
        int guard;
        guard = 0;
        f_addr = -1; op_seen = -1; regs_seen = -1; op_after = -1;
        rf_n = 0; mem_n = 0; both = 0; rd_hold = 1;
        branch  = br;
        alu_out = alu;
        zero    = 1'($urandom_range(0, 1));
        equal   = 1'($urandom_range(0, 1));
        while (!imem_rd && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!imem_rd) begin
            chk("fetch_timeout", int'(imem_rd), 1);
            return;
        end
        f_addr = int'(imem_addr);
        repeat (wt) begin
            imem_valid = 1'b0;
            @(negedge clk);
            rd_hold &= int'(imem_rd);
        end
        imem_data  = instr;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 16'($urandom);
        op_seen   = int'(op);
        regs_seen = int'({rd_addr, ra_addr, rb_addr});
        for (int k = 0; k < 4; k++) begin
            rf_n  += int'(rf_we);
            mem_n += int'(mem_we);
            both  |= int'(rf_we & mem_we);
            if (k < 3) @(negedge clk);
        end
        op_after = int'(op);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_state"}, int'(state), int'(ST_IDLE));
        chk({tag, "_pc"}, int'(pc), 0);
        chk({tag, "_imem_addr"}, int'(imem_addr), 0);
        chk({tag, "_imem_rd"}, int'(imem_rd), 0);
        chk({tag, "_op"}, int'(op), 0);
        chk({tag, "_regs"}, int'({rd_addr, ra_addr, rb_addr}), 0);
        chk({tag, "_strobes"}, int'({rf_we, mem_we}), 0);
        chk({tag, "_busy_halted"}, int'({busy, halted}), 0);
        chk({tag, "_illegal"}, int'(illegal), 0);
        chk({tag, "_cnt"}, int'(instr_cnt), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int fa, ops, regs, rfn, memn, both, hold, opa;
        int m_pc, m_cnt, m_ill, m_op, off, n_pc;
        logic [15:0] r_instr, r_alu;
        logic [1:0]  r_br;
        int r_wt;
        string nm;

        reset = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_data = '0;
        zero = 1'b0; equal = 1'b0; branch = BR_NONE; alu_out = '0;

        //               instr     wt br     alu       op  rf mem pc   ill halt
        vt[0]  = '{16'h2123, 2, 2'b00, 16'h0000,  2, 1, 0,   1, 0, 0};
        vt[1]  = '{16'hA000, 0, 2'b10, 16'h0005, 10, 0, 0,   5, 0, 0};
        vt[2]  = '{16'h512E, 1, 2'b01, 16'h0000,  5, 0, 0,   4, 0, 0};
        vt[3]  = '{16'h512E, 0, 2'b00, 16'h0000,  5, 0, 0,   5, 0, 0};
        vt[4]  = '{16'hA000, 3, 2'b10, 16'h00A7, 10, 0, 0, 167, 0, 0};
        vt[5]  = '{16'h0000, 0, 2'b10, 16'h0033,  0, 0, 0, 168, 0, 0};
        vt[6]  = '{16'hC000, 1, 2'b00, 16'h0000, 12, 0, 0, 169, 1, 0};
        vt[7]  = '{16'hA000, 0, 2'b10, 16'h12FF, 10, 0, 0, 255, 1, 0};
        vt[8]  = '{16'h3456, 0, 2'b00, 16'h0000,  3, 1, 0,   0, 1, 0};
        vt[9]  = '{16'h5108, 2, 2'b01, 16'h0000,  5, 0, 0, 249, 1, 0};
        vt[10] = '{16'h9ABC, 0, 2'b01, 16'h0000,  9, 1, 0, 250, 1, 0};
        vt[11] = '{16'h6000, 1, 2'b00, 16'h0000,  6, 0, 1, 251, 1, 0};
        vt[12] = '{16'h1000, 0, 2'b00, 16'h0000,  1, 0, 0, 251, 1, 1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        // Directed program from PC 0.
        pulse_start();
        m_pc = 0;
        for (int i = 0; i < 13; i++) begin
            run_instr(vt[i].instr, vt[i].wt, vt[i].br, vt[i].alu,
                      fa, ops, regs, rfn, memn, both, hold, opa);
            nm = $sformatf("vec%0d", i);
            chk({nm, "_fetch_addr"}, fa, m_pc);
            chk({nm, "_op"}, ops, vt[i].e_op);
            chk({nm, "_regs"}, regs, int'(vt[i].instr[11:0]));
            chk({nm, "_rf_we"}, rfn, vt[i].e_rf);
            chk({nm, "_mem_we"}, memn, vt[i].e_mem);
            chk({nm, "_we_excl"}, both, 0);
            chk({nm, "_rd_hold"}, hold, 1);
            chk({nm, "_op_after"}, opa, 0);
            chk({nm, "_pc"}, int'(pc), vt[i].e_pc);
            chk({nm, "_cnt"}, int'(instr_cnt), (i + 1) % CNT_MOD);
            chk({nm, "_illegal"}, int'(illegal), vt[i].e_ill);
            chk({nm, "_halted"}, int'(halted), vt[i].e_halt);
            chk({nm, "_busy"}, int'(busy), 1 - vt[i].e_halt);
            m_pc = vt[i].e_pc;
        end

        // HALTED ignores START and IMEM responses.
        start = 1'b1; imem_valid = 1'b1; imem_data = 16'h2123; branch = BR_ABS;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            nm = $sformatf("halt%0d", k);
            chk({nm, "_halted"}, int'(halted), 1);
            chk({nm, "_busy"}, int'(busy), 0);
            chk({nm, "_pc"}, int'(pc), 251);
            chk({nm, "_op_strobes"}, int'({op, rf_we, mem_we, imem_rd}), 0);
            chk({nm, "_cnt"}, int'(instr_cnt), 13 % CNT_MOD);
        end
        start = 1'b0; imem_valid = 1'b0;

        do_reset();
        check_reset_state("reset2");

        // Random stream against the behavioural model (halt excluded).
        pulse_start();
        m_pc = 0; m_cnt = 0; m_ill = 0;
        for (int i = 0; i < 150; i++) begin
            do m_op = $urandom_range(0, 15); while (m_op == 1);
            r_instr = {4'(m_op), 12'($urandom)};
            r_br    = 2'($urandom_range(0, 3));
            r_alu   = 16'($urandom);
            r_wt    = $urandom_range(0, 3);
            run_instr(r_instr, r_wt, r_br, r_alu, fa, ops, regs, rfn, memn, both, hold, opa);
            n_pc = (m_pc + 1) % PC_MOD;
            if (m_op == 5 || m_op == 10) begin
                if (r_br == 2'b01) begin
                    off  = int'(r_instr[3:0]);
                    if (off >= 8) off -= 16;
                    n_pc = (m_pc + 1 + off + PC_MOD) % PC_MOD;
                end else if (r_br == 2'b10) begin
                    n_pc = int'(r_alu) % PC_MOD;
                end
            end
            if (m_op >= 11) m_ill = 1;
            m_cnt = (m_cnt + 1) % CNT_MOD;
            nm = $sformatf("rnd%0d", i);
            chk({nm, "_fetch_addr"}, fa, m_pc);
            chk({nm, "_op"}, ops, m_op);
            chk({nm, "_rf_we"}, rfn, (m_op inside {2, 3, 4, 7, 8, 9}) ? 1 : 0);
            chk({nm, "_mem_we"}, memn, (m_op == 6) ? 1 : 0);
            chk({nm, "_pc"}, int'(pc), n_pc);
            chk({nm, "_cnt"}, int'(instr_cnt), m_cnt);
            chk({nm, "_illegal"}, int'(illegal), m_ill);
            m_pc = n_pc;
        end

        // Reset while a fetch is pending, then a late response.
        chk("prefetch_rd", int'(imem_rd), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstfetch_state", int'(state), int'(ST_IDLE));
        chk("rstfetch_pc", int'(pc), 0);
        chk("rstfetch_rd", int'(imem_rd), 0);
        chk("rstfetch_cnt", int'(instr_cnt), 0);
        imem_data  = 16'h3FFF;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        chk("late_valid_state", int'(state), int'(ST_IDLE));
        chk("late_valid_regs", int'({rd_addr, ra_addr, rb_addr}), 0);
        chk("late_valid_op", int'(op), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
